dmem_ctrl: RTL and testbench

- Multi-cycle access controller between the MEM pipeline stage and a single-port data memory with a ready handshake.
- Latches one load/store request, then drives byte enables and lane-replicated write data, and waits for mem_ready.
- Returns sign- or zero-extended load data.
- Stalls the pipeline while an access is in flight and flags misaligned requests without touching memory.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_ctrl_if.sv | 25 ++
 rtl/dmem_lane_align.sv | 46 ++++
 rtl/dmem_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access controller.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] BE_ALL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_ctrl_if.sv
// Single-port data-memory bus with ready handshake.
// master: access controller side; slave: memory side.
interface dmem_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: byte enables, store replication, load
// shift/extension and the misalignment check. Purely combinational.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [31:0] shifted;

  // Lane selection per access size; size 11 falls into the word case.
  always_comb begin
    be         = BE_ALL;
    wdata_rep  = wdata;
    misaligned = 1'b0;
    shifted    = rdata >> {addr_lo, 3'b000};
    rdata_ext  = shifted;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = is_unsigned ? {24'h000000, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = is_unsigned ? {16'h0000, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle MEM-stage data-memory access controller.
// Optional macro DMEM_CTRL_TIMEOUT_EN: abort an ACCESS after TIMEOUT
// cycles without mem_ready and report rsp_err.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              misalign_err,
  dmem_ctrl_if.master       mem
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              we_q;
  logic [31:0]       rdata_q;

  logic              idle;
  logic              req_any;
  logic              accept;
  logic              timeout;
  logic [3:0]        la_be;
  logic [31:0]       la_wdata;
  logic [31:0]       la_rdata;
  logic              la_mis;

  logic              en;
  logic              we;
  logic [3:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;

  assign idle    = (state_q == IDLE);
  assign req_any = req_read | req_write;
  assign accept  = idle & req_any & ~la_mis;

  // One lane aligner serves both phases: in IDLE it sees the live request
  // (misalignment check), otherwise the latched request (lanes, load data).
  dmem_lane_align u_align (
    .addr_lo     (idle ? req_addr[1:0] : addr_q[1:0]),
    .size        (idle ? req_size      : size_q),
    .is_unsigned (idle ? req_unsigned  : uns_q),
    .wdata       (wdata_q),
    .rdata       (mem.mem_rdata),
    .be          (la_be),
    .wdata_rep   (la_wdata),
    .rdata_ext   (la_rdata),
    .misaligned  (la_mis)
  );

`ifdef DMEM_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // ACCESS cycle counter, cleared on every accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (state_q == ACCESS && !mem.mem_ready) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout = (state_q == ACCESS) & ~mem.mem_ready & (cnt_q == CNT_W'(TIMEOUT - 1));

  // Error flag for the pending response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == ACCESS) begin
      err_q <= timeout;
    end
  end

  assign rsp_err = (state_q == RESP) & err_q;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and bus/handshake outputs.
  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    misalign_err = 1'b0;
    rsp_valid    = 1'b0;
    en           = 1'b0;
    we           = 1'b0;
    be           = '0;
    addr         = '0;
    wdata        = '0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          if (la_mis) begin
            misalign_err = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        stall = 1'b1;
        en    = 1'b1;
        we    = we_q;
        be    = la_be;
        addr  = {addr_q[ADDR_W-1:2], 2'b00};
        wdata = la_wdata;
        if (mem.mem_ready || timeout) begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch; a simultaneous read+write is taken as a store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      we_q    <= req_write;
    end
  end

  // Response data capture: extended load data, zero for stores/timeouts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (state_q == ACCESS) begin
      if (mem.mem_ready) begin
        rdata_q <= we_q ? '0 : la_rdata;
      end else if (timeout) begin
        rdata_q <= '0;
      end
    end
  end

  assign rsp_rdata     = rdata_q;
  assign mem.mem_en    = en;
  assign mem.mem_we    = we;
  assign mem.mem_be    = be;
  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = wdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: vector table plus hand-written
// sequences for response timing, reset abandon and timeout behaviour.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic        stall, rsp_valid, rsp_err, misalign_err;
  logic [31:0] rsp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_ctrl_if #(.ADDR_W(32)) mem ();

  dmem_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .stall        (stall),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .misalign_err (misalign_err),
    .mem          (mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    int          acc;
    logic [31:0] mrd;
    logic        mis;
    logic        we;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_req();
    req_read  = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_size  = '0;
    req_unsigned = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_misalign"}, misalign_err, 0);
    chk({tag, "_mem_en"}, mem.mem_en, 0);
    chk({tag, "_mem_we"}, mem.mem_we, 0);
    chk({tag, "_mem_be"}, mem.mem_be, 0);
    chk({tag, "_mem_addr"}, mem.mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem.mem_wdata, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
  endtask

  // Response monitor: pops the scoreboard on every completion pulse.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_rsp", 1, 0);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err, {31'b0, e.err});
      end
    end
  end

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    req_read = v.rd; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    req_size = v.size; req_unsigned = v.uns;
    #1;
    if (v.mis) begin
      chk({v.name, "_misalign"}, misalign_err, 1);
      chk({v.name, "_stall"}, stall, 0);
      chk({v.name, "_mem_en"}, mem.mem_en, 0);
      @(negedge clk);
      clear_req();
      #1;
      chk({v.name, "_idle_mem_en"}, mem.mem_en, 0);
      chk({v.name, "_idle_stall"}, stall, 0);
      chk({v.name, "_mis_pulse"}, misalign_err, 0);
      return;
    end
    chk({v.name, "_req_stall"}, stall, 1);
    chk({v.name, "_req_misalign"}, misalign_err, 0);
    sb.push_back('{v.rdata, 1'b0});
    for (int i = 1; i <= v.acc; i++) begin
      @(negedge clk);
      if (i == 1) clear_req();
      mem.mem_ready = (i == v.acc);
      mem.mem_rdata = (i == v.acc) ? v.mrd : $urandom();
      #1;
      chk({v.name, "_acc_stall"}, stall, 1);
      chk({v.name, "_acc_en"}, mem.mem_en, 1);
      chk({v.name, "_acc_rsp_valid"}, rsp_valid, 0);
      if (i == 1) begin
        chk({v.name, "_we"}, mem.mem_we, v.we);
        chk({v.name, "_be"}, mem.mem_be, v.be);
        chk({v.name, "_addr"}, mem.mem_addr, v.maddr);
        chk({v.name, "_wdata"}, mem.mem_wdata, v.mwdata);
      end
    end
    @(negedge clk);
    mem.mem_ready = 1'b0;
    mem.mem_rdata = $urandom();
    #1;
    chk({v.name, "_resp_valid"}, rsp_valid, 1);
    chk({v.name, "_resp_stall"}, stall, 0);
    chk({v.name, "_resp_en"}, mem.mem_en, 0);
    @(negedge clk);
    #1;
    chk({v.name, "_pulse_end"}, rsp_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{"ld_w_100",     1,0,32'h100,32'h0,       2'b10,0,2,32'hDEADBEEF,0,0,4'b1111,32'h100,32'h0,       32'hDEADBEEF});
    vecs.push_back('{"ld_b_s_103",   1,0,32'h103,32'h0,       2'b00,0,1,32'h80FF0000,0,0,4'b1000,32'h100,32'h0,       32'hFFFFFF80});
    vecs.push_back('{"ld_b_u_103",   1,0,32'h103,32'h0,       2'b00,1,3,32'h80FF0000,0,0,4'b1000,32'h100,32'h0,       32'h00000080});
    vecs.push_back('{"st_h_0a",      0,1,32'h0A, 32'h1234ABCD,2'b01,0,1,32'h55555555,0,1,4'b1100,32'h08, 32'hABCDABCD,32'h0});
    vecs.push_back('{"ld_w_102_mis", 1,0,32'h102,32'h0,       2'b10,0,1,32'h0,       1,0,4'b0000,32'h0,  32'h0,       32'h0});
    vecs.push_back('{"ld_h_101_mis", 1,0,32'h101,32'h0,       2'b01,0,1,32'h0,       1,0,4'b0000,32'h0,  32'h0,       32'h0});
    vecs.push_back('{"ld_h_s_102",   1,0,32'h102,32'h0,       2'b01,0,1,32'h80011234,0,0,4'b1100,32'h100,32'h0,       32'hFFFF8001});
    vecs.push_back('{"ld_h_u_100",   1,0,32'h100,32'h0,       2'b01,1,2,32'h1234F00D,0,0,4'b0011,32'h100,32'h0,       32'h0000F00D});
    vecs.push_back('{"st_b_201",     0,1,32'h201,32'hFFFFFFA5,2'b00,0,1,32'h0,       0,1,4'b0010,32'h200,32'hA5A5A5A5,32'h0});
    vecs.push_back('{"rw_both_10",   1,1,32'h10, 32'hCAFEF00D,2'b10,0,1,32'h77777777,0,1,4'b1111,32'h10, 32'hCAFEF00D,32'h0});
    vecs.push_back('{"ld_sz3_20",    1,0,32'h20, 32'h0,       2'b11,0,1,32'h12345678,0,0,4'b1111,32'h20, 32'h0,       32'h12345678});
    vecs.push_back('{"ld_sz3_21_mis",1,0,32'h21, 32'h0,       2'b11,0,1,32'h0,       1,0,4'b0000,32'h0,  32'h0,       32'h0});
    vecs.push_back('{"ld_b_u_102",   1,0,32'h102,32'h0,       2'b00,1,1,32'h00AB0000,0,0,4'b0100,32'h100,32'h0,       32'h000000AB});
    vecs.push_back('{"st_h_100",     0,1,32'h100,32'h00008765,2'b01,0,2,32'h0,       0,1,4'b0011,32'h100,32'h87658765,32'h0});
    vecs.push_back('{"ld_b_s_101",   1,0,32'h101,32'h0,       2'b00,0,1,32'h00007F00,0,0,4'b0010,32'h100,32'h0,       32'h0000007F});
    vecs.push_back('{"st_h_03_mis",  0,1,32'h03, 32'h1111,    2'b01,0,1,32'h0,       1,0,4'b0000,32'h0,  32'h0,       32'h0});

    mem.mem_ready = 1'b0;
    mem.mem_rdata = '0;
    #1 rst = 1'b1;
    #1 chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Request held through ACCESS and RESP: ignored in RESP, taken in IDLE.
    @(negedge clk);
    req_read = 1'b1; req_addr = 32'h40; req_size = 2'b10;
    sb.push_back('{32'h11112222, 1'b0});
    #1 chk("hold_req_stall", stall, 1);
    @(negedge clk);
    mem.mem_ready = 1'b1; mem.mem_rdata = 32'h11112222;
    #1 chk("hold_acc_en", mem.mem_en, 1);
    @(negedge clk);
    mem.mem_ready = 1'b0; mem.mem_rdata = '0;
    #1;
    chk("hold_resp_valid", rsp_valid, 1);
    chk("hold_resp_stall", stall, 0);
    chk("hold_resp_en", mem.mem_en, 0);
    @(negedge clk);
    #1;
    chk("hold_idle_stall", stall, 1);
    chk("hold_idle_en", mem.mem_en, 0);
    sb.push_back('{32'h33334444, 1'b0});
    @(negedge clk);
    clear_req();
    mem.mem_ready = 1'b1; mem.mem_rdata = 32'h33334444;
    #1;
    chk("hold2_acc_en", mem.mem_en, 1);
    chk("hold2_acc_addr", mem.mem_addr, 32'h40);
    @(negedge clk);
    mem.mem_ready = 1'b0;
    #1 chk("hold2_resp_valid", rsp_valid, 1);
    @(negedge clk);
    #1 chk("hold2_pulse_end", rsp_valid, 0);

    // Reset during ACCESS abandons the access with no response.
    @(negedge clk);
    req_read = 1'b1; req_addr = 32'h80; req_size = 2'b10;
    @(negedge clk);
    clear_req();
    #1 chk("rst_mid_acc_en", mem.mem_en, 1);
    rst = 1'b1;
    sb.delete();
    #1 chk_all_zero("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[0]);

    // Long wait with mem_ready low.
    @(negedge clk);
    req_read = 1'b1; req_addr = 32'h300; req_size = 2'b10;
`ifdef DMEM_CTRL_TIMEOUT_EN
    sb.push_back('{32'h0, 1'b1});
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      clear_req();
      mem.mem_rdata = 32'hFFFFFFFF;
      #1;
      chk("to_acc_stall", stall, 1);
      chk("to_acc_en", mem.mem_en, 1);
      chk("to_acc_no_rsp", rsp_valid, 0);
    end
    @(negedge clk);
    #1;
    chk("to_resp_valid", rsp_valid, 1);
    chk("to_resp_err", rsp_err, 1);
    chk("to_resp_rdata", rsp_rdata, 0);
    chk("to_resp_en", mem.mem_en, 0);
    @(negedge clk);
    #1 chk("to_pulse_end", rsp_valid, 0);
`else
    sb.push_back('{32'h00C0FFEE, 1'b0});
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      clear_req();
      #1;
      chk("wait_acc_en", mem.mem_en, 1);
      chk("wait_no_rsp", rsp_valid, 0);
    end
    @(negedge clk);
    mem.mem_ready = 1'b1; mem.mem_rdata = 32'h00C0FFEE;
    @(negedge clk);
    mem.mem_ready = 1'b0;
    #1;
    chk("wait_resp_valid", rsp_valid, 1);
    chk("wait_resp_err", rsp_err, 0);
    @(negedge clk);
    #1 chk("wait_pulse_end", rsp_valid, 0);
`endif

    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
